// File: rtl/iic_pkg.sv
// Shared constants and state encoding for the I2C target controller.
package iic_pkg;
   localparam int unsigned IIC_SYNC_STAGES = 2;
   localparam int unsigned IIC_BITS        = 8;
   localparam int unsigned IIC_ACK_BITS    = 9;

   typedef enum logic [7:0] {
      ST_IDLE      = 8'h01,
      ST_ADDR      = 8'h02,
      ST_ADDR_ACK  = 8'h04,
      ST_WRITE     = 8'h08,
      ST_WR_ACK    = 8'h10,
      ST_READ      = 8'h20,
      ST_RD_ACK    = 8'h40,
      ST_WAIT_STOP = 8'h80
   } iic_state_e;
endpackage

// File: rtl/iic_slave_if.sv
// Byte-port, enable and status bundle between the I2C target and its byte fabric.
interface iic_slave_if;
   logic       DESR;
   logic [7:0] bkp_data_o;
   logic       bkp_ready_o;
   logic [7:0] bkp_data_i;
   logic       bkp_ready_i;
   logic       tx_req_o;
   logic       bkp_busy_o;
   logic       rw_o;
   logic       tx_underrun;
   logic       read_nack;
   logic       noack_clear;

   modport slave (
      input  DESR, bkp_data_i, bkp_ready_i, noack_clear,
      output bkp_data_o, bkp_ready_o, tx_req_o, bkp_busy_o, rw_o, tx_underrun, read_nack
   );

   modport master (
      output DESR, bkp_data_i, bkp_ready_i, noack_clear,
      input  bkp_data_o, bkp_ready_o, tx_req_o, bkp_busy_o, rw_o, tx_underrun, read_nack
   );
endinterface

// File: rtl/iic_line_filter.sv
// Synchronizer plus glitch filter for one bus line; level and edge strobes are registered.
module iic_line_filter
   import iic_pkg::*;
#(
   parameter int unsigned FILTER_LEN = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [IIC_SYNC_STAGES-1:0] sync;
   logic [3:0]                 cnt;
   logic                       sample;

   assign sample = sync[IIC_SYNC_STAGES-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync  <= '1;
         cnt   <= '0;
         level <= 1'b1;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         sync <= {sync[IIC_SYNC_STAGES-2:0], din};
         rise <= 1'b0;
         fall <= 1'b0;
         // a new level needs FILTER_LEN consecutive disagreeing samples
         if (sample == level) begin
            cnt <= '0;
         end else if (cnt == 4'(FILTER_LEN - 1)) begin
            level <= sample;
            cnt   <= '0;
            rise  <= sample;
            fall  <= ~sample;
         end else begin
            cnt <= cnt + 4'd1;
         end
      end
   end

endmodule

// File: rtl/iic_slave.sv
// I2C target: filtered bus decode, address match, write/read byte transfer, open-drain SDA.
module iic_slave
   import iic_pkg::*;
#(
   parameter logic [6:0]  SLAVE_ADDR = 7'h50,
   parameter int unsigned FILTER_LEN = 3
) (
   input  logic  clk,
   input  logic  rst,
   input  logic  SCL,
   inout  wire   SDA,
   iic_slave_if.slave bkp
);

   logic       scl_f, scl_rise, scl_fall;
   logic       sda_f, sda_rise, sda_fall;
   logic       start_c, stop_c;
   iic_state_e state;
   logic [7:0] shift, shift_in, tx_data, tx_byte;
   logic [3:0] bit_cnt;
   logic       tx_valid, sda_oe;

   iic_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl (
      .clk(clk), .rst(rst), .din(SCL), .level(scl_f), .rise(scl_rise), .fall(scl_fall)
   );

   iic_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda (
      .clk(clk), .rst(rst), .din(SDA), .level(sda_f), .rise(sda_rise), .fall(sda_fall)
   );

   assign SDA      = sda_oe ? 1'b0 : 1'bz;
   assign start_c  = sda_fall & scl_f;
   assign stop_c   = sda_rise & scl_f;
   assign shift_in = {shift[6:0], sda_f};
   assign tx_byte  = tx_valid ? tx_data : 8'hFF;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state            <= ST_IDLE;
         shift            <= '0;
         bit_cnt          <= '0;
         sda_oe           <= 1'b0;
         tx_data          <= '0;
         tx_valid         <= 1'b0;
         bkp.bkp_data_o   <= '0;
         bkp.bkp_ready_o  <= 1'b0;
         bkp.tx_req_o     <= 1'b0;
         bkp.bkp_busy_o   <= 1'b0;
         bkp.rw_o         <= 1'b0;
         bkp.tx_underrun  <= 1'b0;
         bkp.read_nack    <= 1'b0;
      end else begin
         bkp.bkp_ready_o <= 1'b0;
         bkp.tx_req_o    <= 1'b0;
         if (bkp.noack_clear) begin
            bkp.tx_underrun <= 1'b0;
            bkp.read_nack   <= 1'b0;
         end
         if (!bkp.DESR) begin
            state           <= ST_IDLE;
            sda_oe          <= 1'b0;
            bit_cnt         <= '0;
            bkp.bkp_busy_o  <= 1'b0;
            bkp.tx_underrun <= 1'b0;
            bkp.read_nack   <= 1'b0;
         end else if (start_c) begin
            state          <= ST_ADDR;
            bit_cnt        <= '0;
            sda_oe         <= 1'b0;
            bkp.bkp_busy_o <= 1'b0;
         end else if (stop_c) begin
            state          <= ST_IDLE;
            sda_oe         <= 1'b0;
            bkp.bkp_busy_o <= 1'b0;
         end else begin
            case (state)
               ST_ADDR: if (scl_rise) begin
                  shift   <= shift_in;
                  bit_cnt <= bit_cnt + 4'd1;
                  if (bit_cnt == 4'(IIC_BITS - 1)) begin
                     if (shift_in[7:1] == SLAVE_ADDR) begin
                        bkp.rw_o       <= shift_in[0];
                        bkp.bkp_busy_o <= 1'b1;
                        bkp.tx_req_o   <= shift_in[0];
                        state          <= ST_ADDR_ACK;
                     end else begin
                        state <= ST_WAIT_STOP;
                     end
                  end
               end
               // bit_cnt = 8 on entry marks "ACK not yet driven", 9 marks "driving"
               ST_ADDR_ACK, ST_WR_ACK: if (scl_fall) begin
                  if (bit_cnt == 4'(IIC_BITS)) begin
                     sda_oe  <= 1'b1;
                     bit_cnt <= 4'(IIC_ACK_BITS);
                  end else begin
                     bit_cnt <= '0;
                     if (bkp.rw_o) begin
                        shift    <= tx_byte;
                        sda_oe   <= ~tx_byte[7];
                        tx_valid <= 1'b0;
                        if (!tx_valid) bkp.tx_underrun <= 1'b1;
                        state    <= ST_READ;
                     end else begin
                        sda_oe <= 1'b0;
                        state  <= ST_WRITE;
                     end
                  end
               end
               ST_WRITE: if (scl_rise) begin
                  shift   <= shift_in;
                  bit_cnt <= bit_cnt + 4'd1;
                  if (bit_cnt == 4'(IIC_BITS - 1)) begin
                     bkp.bkp_data_o  <= shift_in;
                     bkp.bkp_ready_o <= 1'b1;
                     state           <= ST_WR_ACK;
                  end
               end
               ST_READ: begin
                  if (scl_rise) begin
                     bit_cnt <= bit_cnt + 4'd1;
                  end else if (scl_fall) begin
                     if (bit_cnt == 4'(IIC_BITS)) begin
                        sda_oe <= 1'b0;
                        state  <= ST_RD_ACK;
                     end else begin
                        shift  <= {shift[6:0], 1'b0};
                        sda_oe <= ~shift[6];
                     end
                  end
               end
               ST_RD_ACK: begin
                  if (scl_rise) begin
                     if (!sda_f) begin
                        bkp.tx_req_o <= 1'b1;
                     end else begin
                        bkp.read_nack <= 1'b1;
                        state         <= ST_WAIT_STOP;
                     end
                  end else if (scl_fall) begin
                     bit_cnt  <= '0;
                     shift    <= tx_byte;
                     sda_oe   <= ~tx_byte[7];
                     tx_valid <= 1'b0;
                     if (!tx_valid) bkp.tx_underrun <= 1'b1;
                     state    <= ST_READ;
                  end
               end
               ST_IDLE, ST_WAIT_STOP: sda_oe <= 1'b0;
               default: state <= ST_IDLE;
            endcase
         end
         // placed last so a same-cycle load overrides the consume above
         if (bkp.bkp_ready_i) begin
            tx_valid <= 1'b1;
            tx_data  <= bkp.bkp_data_i;
         end
      end
   end

endmodule

// File: tb/tb_iic_slave.sv
// Directed + randomized bus-level bench for iic_slave acting as an I2C master and byte fabric.
module tb_iic_slave;
   logic clk, rst, scl_m, sda_m;
   wire  sda_w;
   int   checks = 0, failures = 0;
   int   txreq_cnt = 0, dut_low = 0;
   logic [7:0] rx_q[$];
   logic [7:0] resp_q[$];

   iic_slave_if bkp ();

   iic_slave #(.SLAVE_ADDR(7'h50), .FILTER_LEN(3)) dut (
      .clk(clk), .rst(rst), .SCL(scl_m), .SDA(sda_w), .bkp(bkp)
   );

   pullup (sda_w);
   assign sda_w = sda_m ? 1'bz : 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic wclk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // fabric side: record written bytes, count requests, spot target-driven lows
   initial forever begin
      @(posedge clk); #2;
      if (bkp.bkp_ready_o) rx_q.push_back(bkp.bkp_data_o);
      if (bkp.tx_req_o) txreq_cnt++;
      if (sda_m && !sda_w) dut_low++;
   end

   initial forever begin
      @(posedge clk); #1;
      if (bkp.tx_req_o && resp_q.size() != 0) begin
         bkp.bkp_data_i  = resp_q.pop_front();
         bkp.bkp_ready_i = 1'b1;
         @(posedge clk); #1;
         bkp.bkp_ready_i = 1'b0;
      end
   end

   task automatic clear_mon();
      rx_q.delete();
      txreq_cnt = 0;
      dut_low = 0;
   endtask

   task automatic i2c_start();
      sda_m = 1'b0; wclk(20); scl_m = 1'b0;
   endtask

   task automatic i2c_rstart();
      wclk(5); sda_m = 1'b1; wclk(15); scl_m = 1'b1; wclk(20); sda_m = 1'b0; wclk(20); scl_m = 1'b0;
   endtask

   task automatic i2c_stop();
      wclk(5); sda_m = 1'b0; wclk(15); scl_m = 1'b1; wclk(20); sda_m = 1'b1; wclk(20);
   endtask

   task automatic put_bit(input logic b, input bit glitch);
      wclk(5); sda_m = b;
      if (glitch) begin
         wclk(5); scl_m = 1'b1; wclk(2); scl_m = 1'b0; wclk(8);
      end else begin
         wclk(15);
      end
      scl_m = 1'b1; wclk(20); scl_m = 1'b0;
   endtask

   task automatic get_bit(output logic b);
      wclk(5); sda_m = 1'b1; wclk(15); scl_m = 1'b1; wclk(10); b = sda_w; wclk(10); scl_m = 1'b0;
   endtask

   task automatic put_byte(input logic [7:0] d, input int gbit, output logic ack);
      for (int i = 7; i >= 0; i--) put_bit(d[i], i == gbit);
      get_bit(ack);
   endtask

   task automatic get_byte(output logic [7:0] d, input logic ack);
      logic b;
      logic [7:0] t;
      for (int i = 7; i >= 0; i--) begin
         get_bit(b);
         t[i] = b;
      end
      d = t;
      put_bit(ack, 1'b0);
   endtask

   initial begin
      logic       ack;
      logic [7:0] d, gb, wb;
      logic [7:0] wr_bytes[4];
      logic [7:0] rd_exp[2];
      int         gpos;

      scl_m = 1'b1; sda_m = 1'b1; rst = 1'b1;
      bkp.DESR = 1'b1; bkp.bkp_data_i = '0; bkp.bkp_ready_i = 1'b0; bkp.noack_clear = 1'b0;
      wclk(4);
      chk("rst_ready", bkp.bkp_ready_o, 0);
      chk("rst_txreq", bkp.tx_req_o, 0);
      chk("rst_busy", bkp.bkp_busy_o, 0);
      chk("rst_rw", bkp.rw_o, 0);
      chk("rst_underrun", bkp.tx_underrun, 0);
      chk("rst_nack", bkp.read_nack, 0);
      chk("rst_data", bkp.bkp_data_o, 8'h00);
      chk("rst_sda", sda_w, 1);
      rst = 1'b0;
      wclk(10);

      // addressed write: spec bytes then two random ones
      wr_bytes[0] = 8'h3C; wr_bytes[1] = 8'h81;
      wr_bytes[2] = 8'($urandom); wr_bytes[3] = 8'($urandom);
      clear_mon();
      i2c_start();
      put_byte(8'hA0, -1, ack);
      chk("wr_addr_ack", ack, 0);
      chk("wr_busy", bkp.bkp_busy_o, 1);
      chk("wr_rw", bkp.rw_o, 0);
      for (int i = 0; i < 4; i++) begin
         put_byte(wr_bytes[i], -1, ack);
         chk("wr_data_ack", ack, 0);
      end
      i2c_stop();
      chk("wr_busy_stop", bkp.bkp_busy_o, 0);
      chk("wr_count", rx_q.size(), 4);
      for (int i = 0; i < 4; i++) chk("wr_byte", (i < rx_q.size()) ? rx_q[i] : 8'hxx, wr_bytes[i]);
      chk("wr_last_data", bkp.bkp_data_o, wr_bytes[3]);

      // address mismatch
      clear_mon();
      i2c_start();
      put_byte(8'hA2, -1, ack);
      chk("mm_addr_nack", ack, 1);
      put_byte(8'h55, -1, ack);
      chk("mm_data_nack", ack, 1);
      i2c_stop();
      chk("mm_pulses", rx_q.size() + txreq_cnt, 0);
      chk("mm_busy", bkp.bkp_busy_o, 0);
      chk("mm_sda_driven", dut_low, 0);

      // two-byte read, ACK then NACK
      clear_mon();
      rd_exp[0] = 8'h96; rd_exp[1] = 8'h5A;
      resp_q.push_back(rd_exp[0]); resp_q.push_back(rd_exp[1]);
      i2c_start();
      put_byte(8'hA1, -1, ack);
      chk("rd_addr_ack", ack, 0);
      chk("rd_rw", bkp.rw_o, 1);
      get_byte(d, 1'b0);
      chk("rd_byte0", d, rd_exp[0]);
      get_byte(d, 1'b1);
      chk("rd_byte1", d, rd_exp[1]);
      i2c_stop();
      chk("rd_txreq_cnt", txreq_cnt, 2);
      chk("rd_nack_flag", bkp.read_nack, 1);
      chk("rd_no_underrun", bkp.tx_underrun, 0);
      bkp.noack_clear = 1'b1; wclk(1); bkp.noack_clear = 1'b0; wclk(1);
      chk("rd_nack_cleared", bkp.read_nack, 0);

      // underrun: no response to the request
      clear_mon();
      i2c_start();
      put_byte(8'hA1, -1, ack);
      chk("ur_addr_ack", ack, 0);
      get_byte(d, 1'b1);
      chk("ur_byte", d, 8'hFF);
      chk("ur_flag", bkp.tx_underrun, 1);
      i2c_stop();
      bkp.noack_clear = 1'b1; wclk(1); bkp.noack_clear = 1'b0; wclk(1);
      chk("ur_cleared", bkp.tx_underrun, 0);
      chk("ur_nack_cleared", bkp.read_nack, 0);

      // repeated START: write one byte, then read one random byte
      clear_mon();
      wb = 8'($urandom);
      rd_exp[0] = 8'($urandom);
      resp_q.push_back(rd_exp[0]);
      i2c_start();
      put_byte(8'hA0, -1, ack);
      put_byte(wb, -1, ack);
      chk("rs_wr_ack", ack, 0);
      chk("rs_rw_before", bkp.rw_o, 0);
      i2c_rstart();
      put_byte(8'hA1, -1, ack);
      chk("rs_addr_ack", ack, 0);
      chk("rs_rw_after", bkp.rw_o, 1);
      get_byte(d, 1'b1);
      chk("rs_rd_byte", d, rd_exp[0]);
      i2c_stop();
      chk("rs_wr_data", bkp.bkp_data_o, wb);
      chk("rs_busy_stop", bkp.bkp_busy_o, 0);

      // SCL glitch inside a random data bit
      clear_mon();
      gb = 8'($urandom);
      gpos = $urandom_range(0, 7);
      i2c_start();
      put_byte(8'hA0, -1, ack);
      put_byte(gb, gpos, ack);
      chk("gl_ack", ack, 0);
      i2c_stop();
      chk("gl_count", rx_q.size(), 1);
      chk("gl_byte", (rx_q.size() != 0) ? rx_q[0] : 8'hxx, gb);

      // reset asserted while the target is driving the address ACK
      clear_mon();
      i2c_start();
      for (int i = 7; i >= 0; i--) put_bit(1'(8'hA0 >> i), 1'b0);
      wclk(5); sda_m = 1'b1; wclk(10);
      chk("rst_mid_ack_driven", sda_w, 0);
      rst = 1'b1; #1;
      chk("rst_mid_ack_released", sda_w, 1);
      chk("rst_mid_busy", bkp.bkp_busy_o, 0);
      wclk(3); rst = 1'b0; wclk(20);
      i2c_stop();

      // target rejoins at the next START
      clear_mon();
      wb = 8'($urandom);
      i2c_start();
      put_byte(8'hA0, -1, ack);
      chk("rj_addr_ack", ack, 0);
      put_byte(wb, -1, ack);
      i2c_stop();
      chk("rj_byte", (rx_q.size() != 0) ? rx_q[0] : 8'hxx, wb);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
